// File: rtl/lab9_soc_otg_hpi_pkg.sv
// Shared constants for the OTG host-port interface responder: register map,
// STATUS bit layout and the HPI data width.
package lab9_soc_otg_hpi_pkg;

    localparam int unsigned HPI_DW = 16;

    typedef logic [HPI_DW-1:0] hpi_word_t;

    localparam logic [1:0] HPI_REG_DATA    = 2'd0;
    localparam logic [1:0] HPI_REG_MAILBOX = 2'd1;
    localparam logic [1:0] HPI_REG_ADDRESS = 2'd2;
    localparam logic [1:0] HPI_REG_STATUS  = 2'd3;

    localparam int unsigned HPI_STAT_MBX_OUT_FULL = 0;
    localparam int unsigned HPI_STAT_MBX_IN_VALID = 1;

    function automatic hpi_word_t hpi_status_word(input logic mbx_out_full,
                                                  input logic mbx_in_valid);
        hpi_word_t w;
        w = '0;
        w[HPI_STAT_MBX_OUT_FULL] = mbx_out_full;
        w[HPI_STAT_MBX_IN_VALID] = mbx_in_valid;
        return w;
    endfunction

endpackage

// File: rtl/lab9_soc_otg_hpi_ram.sv
// Single-port synchronous word RAM behind the HPI DATA register.
// Read-first on a simultaneous write; contents are not reset.
module lab9_soc_otg_hpi_ram
    import lab9_soc_otg_hpi_pkg::*;
#(
    parameter int unsigned MEM_WORDS = 256
) (
    input  logic                         clk_i,
    input  logic                         we_i,
    input  logic [$clog2(MEM_WORDS)-1:0] addr_i,
    input  hpi_word_t                    wdata_i,
    output hpi_word_t                    rdata_o
);

    hpi_word_t mem_q [MEM_WORDS];
    hpi_word_t rdata_q;

    always_ff @(posedge clk_i) begin
        if (we_i) begin
            mem_q[addr_i] <= wdata_i;
        end
        rdata_q <= mem_q[addr_i];
    end

    assign rdata_o = rdata_q;

endmodule

// File: rtl/lab9_soc_otg_hpi_target.sv
// HPI target standing in for the USB controller: registered pin stage,
// strobe edge detection, auto-incrementing RAM pointer and two-way mailbox.
module lab9_soc_otg_hpi_target
    import lab9_soc_otg_hpi_pkg::*;
#(
    parameter int unsigned MEM_WORDS = 256
) (
    input  logic        clk,
    input  logic        reset_n,
    input  logic [1:0]  hpi_address,
    input  logic        hpi_cs_n,
    input  logic        hpi_r_n,
    input  logic        hpi_w_n,
    input  logic [15:0] hpi_data_in,
    output logic [15:0] hpi_data_out,
    output logic        hpi_data_oe,
    output logic        hpi_int,
    output logic [15:0] mbx_in_data,
    output logic        mbx_in_valid,
    input  logic        mbx_in_ack,
    input  logic [15:0] mbx_out_data,
    input  logic        mbx_out_wr
);

    localparam int unsigned AW = $clog2(MEM_WORDS);

    // Pin stage; strobes reset to their inactive level so release of reset
    // never looks like a strobe edge.
    logic       cs_q, r_q, w_q;
    logic [1:0] addr_q;
    hpi_word_t  data_q;

    logic       rd_act_q, rd_act_d;
    logic       wr_act_q, wr_act_d;
    logic [1:0] rd_addr_q, rd_addr_d;
    logic [1:0] wr_addr_q, wr_addr_d;
    hpi_word_t  wr_data_q, wr_data_d;

    hpi_word_t  ptr_q, ptr_d;
    hpi_word_t  mbx_in_data_q, mbx_in_data_d;
    logic       mbx_in_valid_q, mbx_in_valid_d;
    hpi_word_t  mbx_out_q, mbx_out_d;
    logic       mbx_out_full_q, mbx_out_full_d;
    hpi_word_t  data_out_q, data_out_d;
    logic       oe_q, oe_d;

    logic       rd_now, wr_now, rd_done, wr_done;
    logic       ram_we;
    hpi_word_t  ram_rdata;
    hpi_word_t  rd_mux;

    lab9_soc_otg_hpi_ram #(
        .MEM_WORDS (MEM_WORDS)
    ) u_ram (
        .clk_i   (clk),
        .we_i    (ram_we),
        .addr_i  (ptr_q[AW:1]),
        .wdata_i (wr_data_q),
        .rdata_o (ram_rdata)
    );

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            cs_q   <= 1'b1;
            r_q    <= 1'b1;
            w_q    <= 1'b1;
            addr_q <= '0;
            data_q <= '0;
        end else begin
            cs_q   <= hpi_cs_n;
            r_q    <= hpi_r_n;
            w_q    <= hpi_w_n;
            addr_q <= hpi_address;
            data_q <= hpi_data_in;
        end
    end

    // An access only commits if its last low cycle was a legal one, so an
    // r/w overlap can never complete as either a read or a write.
    always_comb begin
        rd_now  = !cs_q && !r_q && w_q;
        wr_now  = !cs_q && !w_q && r_q;
        rd_done = rd_act_q && r_q && !cs_q;
        wr_done = wr_act_q && w_q && !cs_q;
        ram_we  = wr_done && (wr_addr_q == HPI_REG_DATA);
    end

    always_comb begin
        rd_mux = ram_rdata;
        case (rd_addr_q)
            HPI_REG_DATA:    rd_mux = ram_rdata;
            HPI_REG_MAILBOX: rd_mux = mbx_out_q;
            HPI_REG_ADDRESS: rd_mux = ptr_q;
            HPI_REG_STATUS:  rd_mux = hpi_status_word(mbx_out_full_q, mbx_in_valid_q);
            default:         rd_mux = ram_rdata;
        endcase
    end

    always_comb begin
        rd_act_d       = rd_now;
        wr_act_d       = wr_now;
        rd_addr_d      = rd_now ? addr_q : rd_addr_q;
        wr_addr_d      = wr_now ? addr_q : wr_addr_q;
        wr_data_d      = wr_now ? data_q : wr_data_q;
        ptr_d          = ptr_q;
        mbx_in_data_d  = mbx_in_data_q;
        mbx_in_valid_d = mbx_in_valid_q;
        mbx_out_d      = mbx_out_q;
        mbx_out_full_d = mbx_out_full_q;

        if (wr_done) begin
            case (wr_addr_q)
                HPI_REG_ADDRESS: ptr_d = wr_data_q;
                HPI_REG_DATA:    ptr_d = ptr_q + 16'd2;
                default:         ptr_d = ptr_q;
            endcase
        end else if (rd_done && (rd_addr_q == HPI_REG_DATA)) begin
            ptr_d = ptr_q + 16'd2;
        end

        // Host write beats a same-cycle local acknowledge.
        if (mbx_in_ack) begin
            mbx_in_valid_d = 1'b0;
        end
        if (wr_done && (wr_addr_q == HPI_REG_MAILBOX)) begin
            mbx_in_valid_d = 1'b1;
            mbx_in_data_d  = wr_data_q;
        end

        // Local post beats a same-cycle host mailbox read completion.
        if (rd_done && (rd_addr_q == HPI_REG_MAILBOX)) begin
            mbx_out_full_d = 1'b0;
        end
        if (mbx_out_wr) begin
            mbx_out_full_d = 1'b1;
            mbx_out_d      = mbx_out_data;
        end

        oe_d       = rd_act_q && rd_now;
        data_out_d = oe_d ? rd_mux : data_out_q;
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            rd_act_q       <= 1'b0;
            wr_act_q       <= 1'b0;
            rd_addr_q      <= '0;
            wr_addr_q      <= '0;
            wr_data_q      <= '0;
            ptr_q          <= '0;
            mbx_in_data_q  <= '0;
            mbx_in_valid_q <= 1'b0;
            mbx_out_q      <= '0;
            mbx_out_full_q <= 1'b0;
            data_out_q     <= '0;
            oe_q           <= 1'b0;
        end else begin
            rd_act_q       <= rd_act_d;
            wr_act_q       <= wr_act_d;
            rd_addr_q      <= rd_addr_d;
            wr_addr_q      <= wr_addr_d;
            wr_data_q      <= wr_data_d;
            ptr_q          <= ptr_d;
            mbx_in_data_q  <= mbx_in_data_d;
            mbx_in_valid_q <= mbx_in_valid_d;
            mbx_out_q      <= mbx_out_d;
            mbx_out_full_q <= mbx_out_full_d;
            data_out_q     <= data_out_d;
            oe_q           <= oe_d;
        end
    end

    assign hpi_data_out = data_out_q;
    assign hpi_data_oe  = oe_q;
    assign hpi_int      = mbx_out_full_q;
    assign mbx_in_data  = mbx_in_data_q;
    assign mbx_in_valid = mbx_in_valid_q;

endmodule

// File: tb/tb_lab9_soc_otg_hpi_target.sv
// Bench for the HPI target: directed vector table, reset-mid-write sequence,
// then randomized host/local traffic against a register-level model.
module tb_lab9_soc_otg_hpi_target;

    localparam int unsigned MEM_WORDS = 256;

    logic        clk = 1'b0;
    logic        reset_n = 1'b0;
    logic [1:0]  hpi_address = 2'd0;
    logic        hpi_cs_n = 1'b1;
    logic        hpi_r_n = 1'b1;
    logic        hpi_w_n = 1'b1;
    logic [15:0] hpi_data_in = 16'h0;
    logic [15:0] hpi_data_out;
    logic        hpi_data_oe;
    logic        hpi_int;
    logic [15:0] mbx_in_data;
    logic        mbx_in_valid;
    logic        mbx_in_ack = 1'b0;
    logic [15:0] mbx_out_data = 16'h0;
    logic        mbx_out_wr = 1'b0;

    lab9_soc_otg_hpi_target #(
        .MEM_WORDS (MEM_WORDS)
    ) dut (
        .clk          (clk),
        .reset_n      (reset_n),
        .hpi_address  (hpi_address),
        .hpi_cs_n     (hpi_cs_n),
        .hpi_r_n      (hpi_r_n),
        .hpi_w_n      (hpi_w_n),
        .hpi_data_in  (hpi_data_in),
        .hpi_data_out (hpi_data_out),
        .hpi_data_oe  (hpi_data_oe),
        .hpi_int      (hpi_int),
        .mbx_in_data  (mbx_in_data),
        .mbx_in_valid (mbx_in_valid),
        .mbx_in_ack   (mbx_in_ack),
        .mbx_out_data (mbx_out_data),
        .mbx_out_wr   (mbx_out_wr)
    );

    always #5 clk = ~clk;

    int tests = 0;
    int fails = 0;

    typedef enum int {OP_WR, OP_WR_ACK, OP_RD, OP_RD_POST, OP_POST, OP_ACK,
                      OP_ILL, OP_CHK_IN, OP_CHK_INT} op_e;
    typedef struct {
        op_e         op;
        logic [1:0]  addr;
        logic [15:0] data;
        logic [15:0] exp;
        logic        flag;
    } vec_t;

    // Register-level model used by the random phase
    logic [15:0] m_mem [MEM_WORDS];
    int unsigned m_ptr;
    logic [15:0] m_in_data;
    logic        m_in_valid;
    logic [15:0] m_out;
    logic        m_full;

    task automatic chk(input string nm, input logic [15:0] act, input logic [15:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    task automatic write_reg(input logic [1:0] a, input logic [15:0] d, input bit ack_at_commit);
        @(posedge clk); #1;
        hpi_address = a; hpi_data_in = d; hpi_cs_n = 1'b0; hpi_w_n = 1'b0;
        @(posedge clk); @(posedge clk); #1;
        hpi_w_n = 1'b1;
        @(posedge clk); #1;
        hpi_cs_n = 1'b1;
        hpi_data_in = 16'h0;
        if (ack_at_commit) mbx_in_ack = 1'b1;
        @(posedge clk); #1;
        mbx_in_ack = 1'b0;
        @(posedge clk); #1;
    endtask

    task automatic read_reg(input logic [1:0] a, input bit post_at_commit,
                            input logic [15:0] pdata, input logic [15:0] exp,
                            input string nm);
        @(posedge clk); #1;
        hpi_address = a; hpi_cs_n = 1'b0; hpi_r_n = 1'b0;
        @(posedge clk); @(posedge clk); #1;
        chk({nm, "_oe_early"}, {15'd0, hpi_data_oe}, 16'd0);
        @(posedge clk); #1;
        chk({nm, "_oe"}, {15'd0, hpi_data_oe}, 16'd1);
        chk(nm, hpi_data_out, exp);
        @(posedge clk); #1;
        hpi_r_n = 1'b1;
        @(posedge clk); #1;
        hpi_cs_n = 1'b1;
        chk({nm, "_oe_hold"}, {15'd0, hpi_data_oe}, 16'd1);
        if (post_at_commit) begin
            mbx_out_data = pdata; mbx_out_wr = 1'b1;
        end
        @(posedge clk); #1;
        mbx_out_wr = 1'b0;
        chk({nm, "_oe_drop"}, {15'd0, hpi_data_oe}, 16'd0);
        @(posedge clk); #1;
    endtask

    task automatic post(input logic [15:0] d);
        @(posedge clk); #1;
        mbx_out_data = d; mbx_out_wr = 1'b1;
        @(posedge clk); #1;
        mbx_out_wr = 1'b0;
        @(posedge clk); #1;
    endtask

    task automatic ack();
        @(posedge clk); #1;
        mbx_in_ack = 1'b1;
        @(posedge clk); #1;
        mbx_in_ack = 1'b0;
        @(posedge clk); #1;
    endtask

    task automatic illegal(input logic [1:0] a, input logic [15:0] d);
        @(posedge clk); #1;
        hpi_address = a; hpi_data_in = d;
        hpi_cs_n = 1'b0; hpi_r_n = 1'b0; hpi_w_n = 1'b0;
        for (int i = 0; i < 4; i++) begin
            @(posedge clk); #1;
            chk("illegal_oe", {15'd0, hpi_data_oe}, 16'd0);
        end
        hpi_r_n = 1'b1; hpi_w_n = 1'b1;
        @(posedge clk); #1;
        hpi_cs_n = 1'b1;
        @(posedge clk); @(posedge clk); #1;
        chk("illegal_oe_after", {15'd0, hpi_data_oe}, 16'd0);
    endtask

    task automatic chk_model_outputs(input int n);
        chk($sformatf("rnd%0d_int", n), {15'd0, hpi_int}, {15'd0, m_full});
        chk($sformatf("rnd%0d_in_valid", n), {15'd0, mbx_in_valid}, {15'd0, m_in_valid});
        chk($sformatf("rnd%0d_in_data", n), mbx_in_data, m_in_data);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        vec_t vecs[$];
        logic [15:0] d, e;
        int unsigned op;

        // Reset state
        #12;
        chk("rst_data_out", hpi_data_out, 16'h0);
        chk("rst_oe", {15'd0, hpi_data_oe}, 16'd0);
        chk("rst_int", {15'd0, hpi_int}, 16'd0);
        chk("rst_in_data", mbx_in_data, 16'h0);
        chk("rst_in_valid", {15'd0, mbx_in_valid}, 16'd0);
        @(posedge clk); #1;
        reset_n = 1'b1;
        @(posedge clk); #1;

        vecs.push_back('{OP_RD,      2'd2, 16'h0000, 16'h0000, 1'b0});
        vecs.push_back('{OP_WR,      2'd2, 16'h0010, 16'h0000, 1'b0});
        vecs.push_back('{OP_WR,      2'd0, 16'hA5A5, 16'h0000, 1'b0});
        vecs.push_back('{OP_WR,      2'd0, 16'h5A5A, 16'h0000, 1'b0});
        vecs.push_back('{OP_RD,      2'd2, 16'h0000, 16'h0014, 1'b0});
        vecs.push_back('{OP_WR,      2'd2, 16'h0010, 16'h0000, 1'b0});
        vecs.push_back('{OP_RD,      2'd0, 16'h0000, 16'hA5A5, 1'b0});
        vecs.push_back('{OP_RD,      2'd0, 16'h0000, 16'h5A5A, 1'b0});
        vecs.push_back('{OP_WR,      2'd2, 16'h01FE, 16'h0000, 1'b0});
        vecs.push_back('{OP_WR,      2'd0, 16'h1111, 16'h0000, 1'b0});
        vecs.push_back('{OP_WR,      2'd0, 16'h2222, 16'h0000, 1'b0});
        vecs.push_back('{OP_RD,      2'd2, 16'h0000, 16'h0202, 1'b0});
        vecs.push_back('{OP_WR,      2'd2, 16'h0000, 16'h0000, 1'b0});
        vecs.push_back('{OP_RD,      2'd0, 16'h0000, 16'h2222, 1'b0});
        vecs.push_back('{OP_WR,      2'd1, 16'hBEEF, 16'h0000, 1'b0});
        vecs.push_back('{OP_CHK_IN,  2'd0, 16'h0000, 16'hBEEF, 1'b1});
        vecs.push_back('{OP_RD,      2'd3, 16'h0000, 16'h0002, 1'b0});
        vecs.push_back('{OP_WR_ACK,  2'd1, 16'hCAFE, 16'h0000, 1'b0});
        vecs.push_back('{OP_CHK_IN,  2'd0, 16'h0000, 16'hCAFE, 1'b1});
        vecs.push_back('{OP_ACK,     2'd0, 16'h0000, 16'h0000, 1'b0});
        vecs.push_back('{OP_CHK_IN,  2'd0, 16'h0000, 16'hCAFE, 1'b0});
        vecs.push_back('{OP_POST,    2'd0, 16'h1234, 16'h0000, 1'b0});
        vecs.push_back('{OP_CHK_INT, 2'd0, 16'h0000, 16'h0000, 1'b1});
        vecs.push_back('{OP_RD,      2'd3, 16'h0000, 16'h0001, 1'b0});
        vecs.push_back('{OP_RD,      2'd1, 16'h0000, 16'h1234, 1'b0});
        vecs.push_back('{OP_CHK_INT, 2'd0, 16'h0000, 16'h0000, 1'b0});
        vecs.push_back('{OP_POST,    2'd0, 16'h5678, 16'h0000, 1'b0});
        vecs.push_back('{OP_RD_POST, 2'd1, 16'h9ABC, 16'h5678, 1'b0});
        vecs.push_back('{OP_CHK_INT, 2'd0, 16'h0000, 16'h0000, 1'b1});
        vecs.push_back('{OP_RD,      2'd1, 16'h0000, 16'h9ABC, 1'b0});
        vecs.push_back('{OP_CHK_INT, 2'd0, 16'h0000, 16'h0000, 1'b0});
        vecs.push_back('{OP_ILL,     2'd0, 16'hDEAD, 16'h0000, 1'b0});
        vecs.push_back('{OP_CHK_IN,  2'd0, 16'h0000, 16'hCAFE, 1'b0});
        vecs.push_back('{OP_RD,      2'd2, 16'h0000, 16'h0002, 1'b0});
        vecs.push_back('{OP_WR,      2'd2, 16'h0000, 16'h0000, 1'b0});
        vecs.push_back('{OP_RD,      2'd0, 16'h0000, 16'h2222, 1'b0});

        foreach (vecs[i]) begin
            case (vecs[i].op)
                OP_WR:      write_reg(vecs[i].addr, vecs[i].data, 1'b0);
                OP_WR_ACK:  write_reg(vecs[i].addr, vecs[i].data, 1'b1);
                OP_RD:      read_reg(vecs[i].addr, 1'b0, 16'h0, vecs[i].exp, $sformatf("vec%0d_rd", i));
                OP_RD_POST: read_reg(vecs[i].addr, 1'b1, vecs[i].data, vecs[i].exp, $sformatf("vec%0d_rdpost", i));
                OP_POST:    post(vecs[i].data);
                OP_ACK:     ack();
                OP_ILL:     illegal(vecs[i].addr, vecs[i].data);
                OP_CHK_IN: begin
                    chk($sformatf("vec%0d_in_data", i), mbx_in_data, vecs[i].exp);
                    chk($sformatf("vec%0d_in_valid", i), {15'd0, mbx_in_valid}, {15'd0, vecs[i].flag});
                end
                OP_CHK_INT: chk($sformatf("vec%0d_int", i), {15'd0, hpi_int}, {15'd0, vecs[i].flag});
                default: ;
            endcase
        end

        // Reset in the middle of a DATA write
        write_reg(2'd2, 16'h0040, 1'b0);
        write_reg(2'd0, 16'h1357, 1'b0);
        post(16'h4444);
        write_reg(2'd1, 16'h7777, 1'b0);
        write_reg(2'd2, 16'h0040, 1'b0);
        @(posedge clk); #1;
        hpi_address = 2'd0; hpi_data_in = 16'hFFFF; hpi_cs_n = 1'b0; hpi_w_n = 1'b0;
        @(posedge clk); #1;
        reset_n = 1'b0;
        hpi_w_n = 1'b1; hpi_cs_n = 1'b1;
        #1;
        chk("midrst_int", {15'd0, hpi_int}, 16'd0);
        chk("midrst_in_valid", {15'd0, mbx_in_valid}, 16'd0);
        chk("midrst_in_data", mbx_in_data, 16'h0);
        chk("midrst_data_out", hpi_data_out, 16'h0);
        chk("midrst_oe", {15'd0, hpi_data_oe}, 16'd0);
        @(posedge clk); @(posedge clk); #1;
        reset_n = 1'b1;
        @(posedge clk); @(posedge clk); #1;
        chk("postrst_int", {15'd0, hpi_int}, 16'd0);
        chk("postrst_in_valid", {15'd0, mbx_in_valid}, 16'd0);
        read_reg(2'd2, 1'b0, 16'h0, 16'h0000, "postrst_ptr");
        read_reg(2'd1, 1'b0, 16'h0, 16'h0000, "postrst_mbx_out");
        write_reg(2'd2, 16'h0040, 1'b0);
        read_reg(2'd0, 1'b0, 16'h0, 16'h1357, "postrst_ram");

        // Random phase: fill the RAM so every model word is known
        m_ptr = 16'h0042; m_in_data = 16'h0; m_in_valid = 1'b0; m_out = 16'h0; m_full = 1'b0;
        write_reg(2'd2, 16'h0000, 1'b0);
        m_ptr = 0;
        for (int unsigned i = 0; i < MEM_WORDS; i++) begin
            d = 16'($urandom);
            write_reg(2'd0, d, 1'b0);
            m_mem[(m_ptr / 2) % MEM_WORDS] = d;
            m_ptr = (m_ptr + 2) % 65536;
        end

        for (int n = 0; n < 300; n++) begin
            op = $urandom_range(0, 10);
            d  = 16'($urandom);
            case (op)
                0: begin
                    write_reg(2'd2, d, 1'b0);
                    m_ptr = d;
                end
                1, 2: begin
                    write_reg(2'd0, d, 1'b0);
                    m_mem[(m_ptr / 2) % MEM_WORDS] = d;
                    m_ptr = (m_ptr + 2) % 65536;
                end
                3, 4: begin
                    e = m_mem[(m_ptr / 2) % MEM_WORDS];
                    read_reg(2'd0, 1'b0, 16'h0, e, $sformatf("rnd%0d_data", n));
                    m_ptr = (m_ptr + 2) % 65536;
                end
                5: read_reg(2'd2, 1'b0, 16'h0, 16'(m_ptr), $sformatf("rnd%0d_addr", n));
                6: begin
                    write_reg(2'd1, d, ($urandom_range(0, 1) == 1));
                    m_in_data = d; m_in_valid = 1'b1;
                end
                7: begin
                    if ($urandom_range(0, 1) == 1) begin
                        read_reg(2'd1, 1'b1, d, m_out, $sformatf("rnd%0d_mbxpost", n));
                        m_out = d; m_full = 1'b1;
                    end else begin
                        read_reg(2'd1, 1'b0, 16'h0, m_out, $sformatf("rnd%0d_mbx", n));
                        m_full = 1'b0;
                    end
                end
                8: read_reg(2'd3, 1'b0, 16'h0, {14'd0, m_in_valid, m_full}, $sformatf("rnd%0d_status", n));
                9: begin
                    post(d);
                    m_out = d; m_full = 1'b1;
                end
                default: begin
                    if ($urandom_range(0, 1) == 1) begin
                        ack();
                        m_in_valid = 1'b0;
                    end else begin
                        write_reg(2'd3, d, 1'b0);
                    end
                end
            endcase
            chk_model_outputs(n);
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
